// File: rtl/calc_pkg.sv
// calc_pkg: constants and types shared by the calculator display path.
//   - Seven-segment codes, ordered {g,f,e,d,c,b,a}, active-high.
//   - BCD digit width and the number of double-dabble iterations.
//   - Converter FSM state type.
package calc_pkg;

  localparam int BCD_W      = 4;
  localparam int CONV_ITERS = 8;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b1000000;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_e;

endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: combinational BCD digit to seven-segment mapping.
// Ports:
//   digit_i  BCD digit; codes 10..15 produce a blank digit
//   blank_i  force the digit dark (leading-zero blanking)
//   minus_i  show the minus sign; overrides blank_i and digit_i
//   seg_o    segments {g,f,e,d,c,b,a}, active-high
module seg7_encode
  import calc_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  input  logic             blank_i,
  input  logic             minus_i,
  output logic [6:0]       seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (minus_i) begin
      seg_o = SEG_MINUS;
    end else if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bin_to_dec_display.sv
// bin_to_dec_display: converts the calculator's 8-bit result to three BCD
// digits with a sequential double-dabble engine (one iteration per clock)
// and drives a time-multiplexed 4-digit seven-segment display.
// Optional feature macro: SIGNED_RESULT_EN (res is two's complement, the
// magnitude is displayed and digit 3 shows a minus sign when negative).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   res, load             operand and single-cycle conversion request
//   busy, done            conversion in progress / one-cycle commit pulse
//   hundreds, tens, ones  BCD digits of the last completed conversion
//   neg                   sign of the last completed conversion
//   an, seg               one-hot digit enable (bit 0 = ones) and segments
module bin_to_dec_display
  import calc_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       res,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] hundreds,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones,
  output logic             neg,
  output logic [3:0]       an,
  output logic [6:0]       seg
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  conv_state_e      state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [11:0]      scratch_q, scratch_d;
  logic [3:0]       iter_q, iter_d;
  logic             sign_q, sign_d;
  logic [BCD_W-1:0] hundreds_q, hundreds_d, tens_q, tens_d, ones_q, ones_d;
  logic             neg_q, neg_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       scan_idx_q, scan_idx_d;
  logic [3:0]       an_q;
  logic [6:0]       seg_q;

  // Operand selection: magnitude and sign of res at capture time.
  logic [7:0] operand;
  logic       operand_sign;
`ifdef SIGNED_RESULT_EN
  // -8'h80 wraps back to 8'h80, which reads as 128 unsigned.
  assign operand      = res[7] ? 8'(-res) : res;
  assign operand_sign = res[7];
`else
  assign operand      = res;
  assign operand_sign = 1'b0;
`endif

  // Double-dabble step: add 3 to each scratch nibble >= 5, then shift the
  // whole {scratch, shift} word left by one.
  logic [11:0] scratch_adj;
  logic [19:0] dabbled;

  for (genvar gi = 0; gi < 3; gi++) begin : g_adj
    assign scratch_adj[gi*BCD_W +: BCD_W] =
      (scratch_q[gi*BCD_W +: BCD_W] >= 4'd5) ? scratch_q[gi*BCD_W +: BCD_W] + 4'd3
                                              : scratch_q[gi*BCD_W +: BCD_W];
  end

  assign dabbled = {scratch_adj, shift_q} << 1;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    iter_d     = iter_q;
    sign_d     = sign_q;
    hundreds_d = hundreds_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    neg_d      = neg_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          shift_d   = operand;
          scratch_d = '0;
          iter_d    = '0;
          sign_d    = operand_sign;
          state_d   = CONV;
        end
      end
      CONV: begin
        scratch_d = dabbled[19:8];
        shift_d   = dabbled[7:0];
        iter_d    = iter_q + 4'd1;
        if (iter_q == 4'(CONV_ITERS - 1)) begin
          hundreds_d = dabbled[19:16];
          tens_d     = dabbled[15:12];
          ones_d     = dabbled[11:8];
          neg_d      = sign_q;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan: the index advances when the divider wraps; the enable and segment
  // registers load together so an/seg always describe the same digit.
  logic             scan_wrap;
  logic [BCD_W-1:0] sel_digit;
  logic             sel_blank, sel_minus;
  logic [6:0]       sel_seg;

  assign scan_wrap  = (scan_cnt_q == CNT_W'(SCAN_DIV - 1));
  assign scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
  assign scan_idx_d = scan_wrap ? scan_idx_q + 2'd1 : scan_idx_q;

  always_comb begin
    sel_digit = ones_q;
    sel_blank = 1'b0;
    sel_minus = 1'b0;
    case (scan_idx_d)
      2'd0: sel_digit = ones_q;
      2'd1: begin
        sel_digit = tens_q;
        sel_blank = (hundreds_q == '0) && (tens_q == '0);
      end
      2'd2: begin
        sel_digit = hundreds_q;
        sel_blank = (hundreds_q == '0);
      end
      default: begin
        sel_digit = '0;
        sel_blank = 1'b1;
        sel_minus = neg_q;
      end
    endcase
  end

  seg7_encode u_seg7_encode (
    .digit_i (sel_digit),
    .blank_i (sel_blank),
    .minus_i (sel_minus),
    .seg_o   (sel_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      iter_q     <= '0;
      sign_q     <= 1'b0;
      hundreds_q <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      neg_q      <= 1'b0;
      done_q     <= 1'b0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      an_q       <= 4'b0001;
      seg_q      <= SEG_0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      iter_q     <= iter_d;
      sign_q     <= sign_d;
      hundreds_q <= hundreds_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      neg_q      <= neg_d;
      done_q     <= done_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      if (scan_wrap) begin
        an_q  <= 4'b0001 << scan_idx_d;
        seg_q <= sel_seg;
      end
    end
  end

  assign busy     = (state_q == CONV);
  assign done     = done_q;
  assign hundreds = hundreds_q;
  assign tens     = tens_q;
  assign ones     = ones_q;
  assign neg      = neg_q;
  assign an       = an_q;
  assign seg      = seg_q;

endmodule

// File: doc/bin_to_dec_display.md
# bin_to_dec_display

Output-side counterpart of the calculator's decimal key decoder. It takes the calculator's 8-bit binary result and converts it to three BCD digits using a sequential double-dabble engine, one shift-add-3 iteration per clock. It holds the last converted value and drives a time-multiplexed 4-digit seven-segment display. It sits between the calculator's `res` output and the board display pins.

## Interface
- `SCAN_DIV`, default 1024: clocks per displayed digit in the multiplex scan; must be ≥ 2.
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `res`  in  8: binary result from the calculator; sampled only on an accepted `load`.
- `load`  in  1: single-cycle strobe requesting conversion of `res`.
- `busy`  out  1: high while a conversion is in progress.
- `done`  out  1: one-cycle pulse when new BCD digits are committed.
- `hundreds`, `tens`, `ones`  out  4 each: registered BCD digits of the last completed conversion.
- `neg`  out  1: sign of the last completed conversion (see Configuration).
- `an`  out  4: one-hot digit enable, active-high; bit 0 is the ones digit and bit 3 is the sign digit.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, active-high.

## Operation
- **Reset values:** `busy`=0, `done`=0, `hundreds`/`tens`/`ones`=0, `neg`=0, scan index=0, scan counter=0.
  - `an`=4'b0001 and `seg`=7'b0111111 (the digit '0').
- **Converter FSM, state IDLE:**
  - `load`=1 captures the operand (`res`, or its magnitude under the macro) into the shift register and clears the BCD scratch.
  - It also sets the iteration count to 0 and moves to CONV.
- **Converter FSM, state CONV:** each clock performs one double-dabble iteration.
  - Every BCD scratch nibble ≥ 5 has 3 added.
  - Then {scratch, shift} is shifted left by one.
  - After the 8th iteration: commit the scratch to `hundreds`/`tens`/`ones` and the captured sign to `neg`, pulse `done`, return to IDLE.
- **Arithmetic:** the 12-bit scratch holds at most 255, so the `hundreds` nibble never exceeds 2. There is no overflow path.
- **Load while busy:** `load` is ignored; the in-flight result is unaffected.
- **Load on the `done` cycle:** accepted, because the FSM is already in IDLE.
- **Held outputs:** digit outputs and the display keep the previous result during a conversion; they change only at commit.
- **Reset mid-conversion:** reset aborts immediately and all outputs return to their reset values.
- **Scan:**
  - The counter runs 0..`SCAN_DIV`-1. On wrap, the digit index advances 0→1→2→3→0.
  - `an` = one-hot(index). `seg` = encoding of the selected digit.
- **Leading-zero blanking** (blank = 7'b0000000):
  - `hundreds` is blank when it is 0.
  - `tens` is blank when `hundreds` and `tens` are both 0.
  - `ones` is never blanked.
  - Digit 3 is blank unless it shows the minus sign.
  - Minus = 7'b1000000.

## Timing
- Capture edge E0 (`load` sampled high in IDLE); `busy`=1 from E0.
- Iterations on edges E1..E8. At E8: outputs commit, `done`=1, `busy`=0.
- `done` drops at E9.
- Latency is 8 cycles from capture to valid digits. Maximum throughput is one conversion per 9 cycles.
- `an`/`seg` are registered. A digit change appears on the scan edge after commit, together with the current index.

## Configuration
- `SIGNED_RESULT_EN` defined:
  - `res` is two's complement. The converted magnitude is `res` negated when `res[7]`=1; 8'h80 gives 128.
  - `neg` = `res[7]` captured at E0 and committed at E8.
  - Digit 3 shows minus when `neg`=1.
- `SIGNED_RESULT_EN` undefined:
  - `res` is unsigned 0..255.
  - `neg` is tied to 0 and digit 3 is always blank.

## Structure
- **Package `calc_pkg`:** holds the shared constants and the FSM type.
  - Segment constants `SEG_0`..`SEG_9`, `SEG_BLANK`, `SEG_MINUS`.
  - `BCD_W`=4, `CONV_ITERS`=8.
  - The converter state enum {IDLE, CONV}.
- **Sub-module `seg7_encode`:** combinational. Maps a 4-bit BCD digit plus a blank flag and a minus flag to 7 segments. Codes 10..15 map to blank.
- All sequential logic stays in `bin_to_dec_display`.

## Test plan
- **Reset:** assert `rst` mid-scan → all outputs at reset values; `an`=0001, `seg`=0111111.
- **Basic conversion:** `res`=173 with a one-cycle `load` → `busy` for 8 cycles, then `done` pulse with `hundreds`=1, `tens`=7, `ones`=3.
- **Blanking:** `res`=5 → `an`=0100 and `an`=0010 give `seg`=0; `an`=0001 gives SEG_5. `res`=0 → ones shows SEG_0.
- **Collision and abort:**
  - `res`=200 loaded, then `res`=99 with `load` at E3 → result 2/0/0; the second load is ignored.
  - `rst` at E5 → `done` never pulses.
- **Scan rate:** `SCAN_DIV`=4 → `an` steps 0001→0010→0100→1000→0001 every 4 clocks.
- **Signed (`SIGNED_RESULT_EN`):**
  - `res`=8'hF6 → `neg`=1, digits 0/1/0, digit 3 = SEG_MINUS.
  - `res`=8'h80 → 1/2/8, `neg`=1.
  - `res`=8'h7F → 1/2/7, `neg`=0.
